irq_vector_ctrl: RTL and testbench
==================================

IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of request channels (1..8); channel 0 has highest priority.
REQ-002 SHALL have parameter SPUR_VEC, default 16'o000000, vector returned when no request is pending at acknowledge.
REQ-003 SHALL have port clk_p, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port init, input, 1, synchronous bus init (vm_init); clears pending requests.
REQ-006 SHALL have port dev_req, input, NCH, per-channel interrupt request levels from devices.
REQ-007 SHALL have port dev_vec, input, 16*NCH, per-channel vectors; channel k occupies bits [16k+15:16k].
REQ-008 SHALL have port dev_ack, output, NCH, per-channel one-cycle grant pulse.
REQ-009 SHALL have port virq, output, 1, vectored interrupt request to CPU.
REQ-010 SHALL have port istb, input, 1, vector-read strobe from CPU.
REQ-011 SHALL have port ivec, output, 16, vector data to CPU.
REQ-012 SHALL have port iack, output, 1, vector-read acknowledge to CPU.

Function
REQ-013 SHALL hold one pending flag per channel, set in the cycle after a 0->1 transition of dev_req[k] (edge detect via registered copy).
REQ-014 SHALL clear pending[k] when channel k is granted; a new rising edge on the same cycle as the clear SHALL win (flag stays set).
REQ-015 SHALL clear all pending flags and the edge-detect registers (to current dev_req) while init=1; init SHALL also force the FSM to IDLE.
REQ-016 SHALL register virq = OR of pending flags, so virq follows pending with one cycle of latency, and SHALL hold virq at 0 while the FSM is outside IDLE.
REQ-017 SHALL implement FSM states IDLE, SELECT, ACK, RELEASE.
REQ-018 IDLE->SELECT when istb=1.
REQ-019 SELECT (one cycle): latch winner = lowest-numbered pending channel, or "none" if no flag set; load ivec with dev_vec of winner, or SPUR_VEC if none; pulse dev_ack[winner] for exactly this cycle (no pulse if none); clear pending[winner]; ->ACK.
REQ-020 ACK: iack=1, ivec held stable; ->RELEASE when istb=0.
REQ-021 RELEASE (one cycle): iack=0, ivec=0; ->IDLE. No new SELECT SHALL start until istb has been seen low.
REQ-022 If istb drops during SELECT, the FSM SHALL still complete SELECT->ACK->RELEASE; the grant is not cancelled.
REQ-023 Latency: istb rising sampled at edge N -> dev_ack pulse after edge N+1 -> iack=1 after edge N+2; iack falls one cycle after istb falls.
REQ-024 ivec SHALL be 0 whenever iack=0, so it can be ORed onto a shared vector bus.
REQ-025 Requests arriving during SELECT/ACK/RELEASE SHALL be latched as pending and serviced by a later cycle; none are lost.
REQ-026 At most one dev_ack bit SHALL be high in any cycle.

Reset
REQ-027 On rst_n=0, asynchronously: FSM=IDLE, pending=0, edge-detect registers=0, virq=0, iack=0, ivec=0, dev_ack=0.
REQ-028 If dev_req is high at rst_n deassertion, it SHALL register as a rising edge and become pending.
REQ-029 Reset in mid-handshake SHALL abort it immediately with no dev_ack pulse issued afterward.

Verification
REQ-030 Single request: dev_req[2] rises, dev_vec ch2=16'o000060 -> virq=1 two cycles later; istb=1 -> dev_ack=4'b0100 one cycle, then iack=1 with ivec=16'o000060; istb=0 -> iack=0, virq=0.
REQ-031 Priority: ch1 and ch3 rise together -> first handshake returns ch1 vector, virq stays 1, second handshake returns ch3 vector, then virq=0.
REQ-032 Spurious: istb=1 with no pending -> no dev_ack bit, iack=1 with ivec=SPUR_VEC (16'o000000).
REQ-033 Collision: dev_req[0] re-rises in the SELECT cycle that grants ch0 -> pending[0] remains set, virq returns to 1 after RELEASE.
REQ-034 init=1 with ch0 and ch2 pending -> pending cleared, virq=0 next cycle, a following istb yields SPUR_VEC.
REQ-035 rst_n=0 during ACK -> iack, ivec, virq, dev_ack are 0 without waiting for a clock edge; after release, a held-high dev_req becomes pending.

Source files
------------

// File: rtl/irq_vector_ctrl.sv
// ---------------------------------------------------------------------------
// irq_vector_ctrl
//   Vectored interrupt controller. It latches rising edges of per-channel
//   device requests as pending flags and raises virq to the CPU while any
//   flag is pending. On a vector-read strobe it runs a fixed handshake:
//   pick the highest-priority pending channel (channel 0 first), pulse that
//   channel's dev_ack, and present the channel vector on ivec with iack.
//   If nothing is pending, SPUR_VEC is returned instead.
//
// Parameters
//   NCH      number of request channels (1..8), channel 0 highest priority
//   SPUR_VEC vector returned when no request is pending at acknowledge
//
// Ports
//   clk_p    clock, all state changes on its rising edge
//   rst_n    asynchronous active-low reset
//   init     synchronous bus init; clears pending flags, returns FSM to IDLE
//   dev_req  per-channel request levels (edge detected)
//   dev_vec  per-channel vectors, channel k at [16k+15:16k]
//   dev_ack  per-channel one-cycle grant pulse
//   virq     vectored interrupt request to CPU
//   istb     vector-read strobe from CPU
//   ivec     vector data to CPU, zero whenever iack is low
//   iack     vector-read acknowledge to CPU
// ---------------------------------------------------------------------------
module irq_vector_ctrl #(
  parameter int          NCH      = 4,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              init,
  input  logic [NCH-1:0]    dev_req,
  input  logic [16*NCH-1:0] dev_vec,
  output logic [NCH-1:0]    dev_ack,
  output logic              virq,
  input  logic              istb,
  output logic [15:0]       ivec,
  output logic              iack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [NCH-1:0]   req_q, req_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   dev_ack_q, dev_ack_d;
  logic             virq_q, virq_d;
  logic             iack_q, iack_d;
  logic [15:0]      ivec_q, ivec_d;
  logic [15:0]      sel_vec_q, sel_vec_d;

  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   grant;
  logic [15:0]      win_vec;
  logic             found;

  assign rise = dev_req & ~req_q;

  // Fixed-priority pick: lowest-numbered pending channel wins.
  always_comb begin
    grant   = '0;
    win_vec = SPUR_VEC;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (pending_q[k] && !found) begin
        grant[k] = 1'b1;
        win_vec  = dev_vec[16*k +: 16];
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = dev_req;
    pending_d = pending_q | rise;
    dev_ack_d = '0;
    sel_vec_d = sel_vec_q;

    case (state_q)
      IDLE: begin
        if (istb) state_d = SELECT;
      end
      SELECT: begin
        // A rising edge arriving in the same cycle as the grant re-arms the flag.
        state_d   = ACK;
        dev_ack_d = grant;
        sel_vec_d = win_vec;
        pending_d = (pending_q & ~grant) | rise;
      end
      ACK: begin
        if (!istb) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (init) begin
      state_d   = IDLE;
      pending_d = '0;
      dev_ack_d = '0;
    end

    // Outputs are registered copies of the state, so iack/ivec trail ACK by
    // one cycle; ivec is gated so it can be ORed onto a shared bus.
    iack_d = (state_q == ACK) && !init;
    ivec_d = iack_d ? sel_vec_q : 16'h0000;
    virq_d = (state_d == IDLE) && (|pending_q) && !init;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      dev_ack_q <= '0;
      virq_q    <= 1'b0;
      iack_q    <= 1'b0;
      ivec_q    <= 16'h0000;
      sel_vec_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      dev_ack_q <= dev_ack_d;
      virq_q    <= virq_d;
      iack_q    <= iack_d;
      ivec_q    <= ivec_d;
      sel_vec_q <= sel_vec_d;
    end
  end

  assign dev_ack = dev_ack_q;
  assign virq    = virq_q;
  assign iack    = iack_q;
  assign ivec    = ivec_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_vector_ctrl
//   Self-checking bench for irq_vector_ctrl (NCH=4, default SPUR_VEC).
//   Expected grants/vectors are queued as each handshake is started and
//   popped when the DUT answers.
// ---------------------------------------------------------------------------
module tb_irq_vector_ctrl;

  localparam int NCH = 4;
  localparam logic [15:0] SPUR = 16'o000000;
  localparam logic [15:0] V0 = 16'o000100;
  localparam logic [15:0] V1 = 16'o000200;
  localparam logic [15:0] V2 = 16'o000060;
  localparam logic [15:0] V3 = 16'o000300;

  logic              clk_p = 1'b0;
  logic              rst_n = 1'b1;
  logic              init  = 1'b0;
  logic [NCH-1:0]    dev_req = '0;
  logic [16*NCH-1:0] dev_vec = {V3, V2, V1, V0};
  logic [NCH-1:0]    dev_ack;
  logic              virq;
  logic              istb = 1'b0;
  logic [15:0]       ivec;
  logic              iack;

  typedef struct packed {
    logic [NCH-1:0] ack;
    logic [15:0]    vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  irq_vector_ctrl #(.NCH(NCH)) dut (
    .clk_p   (clk_p),
    .rst_n   (rst_n),
    .init    (init),
    .dev_req (dev_req),
    .dev_vec (dev_vec),
    .dev_ack (dev_ack),
    .virq    (virq),
    .istb    (istb),
    .ivec    (ivec),
    .iack    (iack)
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk_p);
  endtask

  // Drives one vector-read handshake and records what the DUT returned.
  // seq_ok reports whether the cycle-by-cycle shape of the handshake held.
  task automatic handshake(input logic [NCH-1:0] raise, input logic drop_early,
                           output logic [NCH-1:0] ack_o, output logic [15:0] vec_o,
                           output logic seq_ok);
    seq_ok = 1'b1;
    istb = 1'b1;
    step();
    if (dev_ack !== '0 || iack !== 1'b0 || virq !== 1'b0) seq_ok = 1'b0;
    dev_req = dev_req | raise;
    if (drop_early) istb = 1'b0;
    step();
    ack_o = dev_ack;
    if (iack !== 1'b0 || ivec !== 16'h0000) seq_ok = 1'b0;
    step();
    vec_o = ivec;
    if (iack !== 1'b1 || dev_ack !== '0) seq_ok = 1'b0;
    if (!drop_early) begin
      istb = 1'b0;
      step();
      if (iack !== 1'b1) seq_ok = 1'b0;
    end
    step();
    if (iack !== 1'b0 || ivec !== 16'h0000) seq_ok = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_tests++; if (iack !== 1'b0) begin n_fail++; $display("FAIL reset_iack got=%b exp=0", iack); end
    n_tests++; if (ivec !== 16'h0000) begin n_fail++; $display("FAIL reset_ivec got=%o exp=0", ivec); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL reset_virq got=%b exp=0", virq); end
    n_tests++; if (dev_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_dev_ack got=%b exp=0000", dev_ack); end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL reset_idle_virq got=%b exp=0", virq); end
  endtask

  task automatic test_single();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b0100;
    step();
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL single_virq_early got=%b exp=0", virq); end
    step();
    n_tests++; if (virq !== 1'b1) begin n_fail++; $display("FAIL single_virq got=%b exp=1", virq); end
    sb_q.push_back('{ack: 4'b0100, vec: V2});
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL single_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL single_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timing got=%b exp=1", ok); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL single_virq_after got=%b exp=0", virq); end
    dev_req = '0;
    step();
  endtask

  task automatic test_priority();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b1010;
    step(); step();
    sb_q.push_back('{ack: 4'b0010, vec: V1});
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL prio1_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL prio1_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL prio1_timing got=%b exp=1", ok); end
    n_tests++; if (virq !== 1'b1) begin n_fail++; $display("FAIL prio_virq_mid got=%b exp=1", virq); end
    sb_q.push_back('{ack: 4'b1000, vec: V3});
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL prio2_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL prio2_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL prio2_timing got=%b exp=1", ok); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL prio_virq_end got=%b exp=0", virq); end
    dev_req = '0;
    step();
  endtask

  task automatic test_spurious();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    sb_q.push_back('{ack: 4'b0000, vec: SPUR});
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL spur_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL spur_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL spur_timing got=%b exp=1", ok); end
  endtask

  task automatic test_collision();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b0001;
    step(); step();
    dev_req = 4'b0000;
    sb_q.push_back('{ack: 4'b0001, vec: V0});
    sb_q.push_back('{ack: 4'b0001, vec: V0});
    handshake(4'b0001, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL coll1_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL coll1_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (virq !== 1'b1) begin n_fail++; $display("FAIL coll_virq_rearm got=%b exp=1", virq); end
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL coll2_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll2_timing got=%b exp=1", ok); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL coll_virq_end got=%b exp=0", virq); end
    dev_req = '0;
    step();
  endtask

  task automatic test_init();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b0101;
    step(); step();
    n_tests++; if (virq !== 1'b1) begin n_fail++; $display("FAIL init_pre_virq got=%b exp=1", virq); end
    init = 1'b1;
    step();
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL init_virq got=%b exp=0", virq); end
    init = 1'b0;
    step();
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL init_virq_hold got=%b exp=0", virq); end
    sb_q.push_back('{ack: 4'b0000, vec: SPUR});
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL init_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL init_vec got=%o exp=%o", v, e.vec); end
    dev_req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b1000;
    step(); step();
    istb = 1'b1;
    step(); step();
    n_tests++; if (dev_ack !== 4'b1000) begin n_fail++; $display("FAIL rmid_grant got=%b exp=1000", dev_ack); end
    step();
    n_tests++; if (iack !== 1'b1) begin n_fail++; $display("FAIL rmid_iack_pre got=%b exp=1", iack); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (iack !== 1'b0) begin n_fail++; $display("FAIL rmid_iack got=%b exp=0", iack); end
    n_tests++; if (ivec !== 16'h0000) begin n_fail++; $display("FAIL rmid_ivec got=%o exp=0", ivec); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL rmid_virq got=%b exp=0", virq); end
    n_tests++; if (dev_ack !== 4'b0000) begin n_fail++; $display("FAIL rmid_dev_ack got=%b exp=0000", dev_ack); end
    istb = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_tests++; if (dev_ack !== 4'b0000) begin n_fail++; $display("FAIL rmid_no_pulse got=%b exp=0000", dev_ack); end
    step();
    n_tests++; if (virq !== 1'b1) begin n_fail++; $display("FAIL rmid_held_req got=%b exp=1", virq); end
    sb_q.push_back('{ack: 4'b1000, vec: V3});
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL rmid_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL rmid_vec got=%o exp=%o", v, e.vec); end
    dev_req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b0010;
    step(); step();
    sb_q.push_back('{ack: 4'b0010, vec: V1});
    sb_q.push_back('{ack: 4'b0100, vec: V2});
    handshake(4'b0100, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL b2b1_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL b2b1_vec got=%o exp=%o", v, e.vec); end
    handshake('0, 1'b0, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL b2b2_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL b2b2_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b2_timing got=%b exp=1", ok); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL b2b_virq_end got=%b exp=0", virq); end
    dev_req = '0;
    step();
  endtask

  task automatic test_istb_drop();
    logic [NCH-1:0] a; logic [15:0] v; logic ok; exp_t e;
    dev_req = 4'b0010;
    step(); step();
    sb_q.push_back('{ack: 4'b0010, vec: V1});
    handshake('0, 1'b1, a, v, ok);
    e = sb_q.pop_front();
    n_tests++; if (a !== e.ack) begin n_fail++; $display("FAIL drop_ack got=%b exp=%b", a, e.ack); end
    n_tests++; if (v !== e.vec) begin n_fail++; $display("FAIL drop_vec got=%o exp=%o", v, e.vec); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL drop_timing got=%b exp=1", ok); end
    n_tests++; if (virq !== 1'b0) begin n_fail++; $display("FAIL drop_virq got=%b exp=0", virq); end
    dev_req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_spurious();
    test_collision();
    test_init();
    test_reset_mid();
    test_back_to_back();
    test_istb_drop();
    n_tests++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
